// File: rtl/fir_filter_mac.sv
// Time-multiplexed FIR filter: one multiply-accumulate unit walks the taps for each
// accepted sample, then rounds, shifts and saturates the result into y_out.
module fir_filter_mac #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 8,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [DATA_W-1:0]    x_in,
    input  logic                        x_valid,
    output logic                        x_ready,
    input  logic                        coef_we,
    input  logic [$clog2(TAPS)-1:0]     coef_addr,
    input  logic signed [COEF_W-1:0]    coef_data,
    output logic signed [OUT_W-1:0]     y_out,
    output logic                        y_valid,
    output logic                        sat_flag
);

    // state | meaning
    // IDLE  | waiting for a sample; coefficient writes accepted
    // MAC   | one tap per cycle, result registered on the last tap

    localparam int AW        = $clog2(TAPS);
    localparam int PW        = DATA_W + COEF_W;
    localparam int ACC_W     = DATA_W + COEF_W + $clog2(TAPS);
    localparam int RW        = ACC_W + 1;
    localparam int CW        = ((RW > OUT_W) ? RW : OUT_W) + 1;
    localparam int RND_SH    = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam int ROUND_ADD = (SHIFT > 0) ? (1 << RND_SH) : 0;

    localparam logic signed [CW-1:0] MAX_C = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [CW-1:0] MIN_C = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic {IDLE, MAC} state_t;

    state_t state, state_next;
    logic   accept, mac_last, addr_ok, coef_ok;

    logic signed [DATA_W-1:0] d [TAPS];
    logic signed [COEF_W-1:0] c [TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic [AW-1:0]            k;

    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [RW-1:0]     rnd;
    logic signed [CW-1:0]     r_w;
    logic [OUT_W-1:0]         y_next;
    logic                     sat_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        mac_last   = 1'b0;
        x_ready    = 1'b0;
        case (state)
            IDLE: begin
                x_ready = !reset;
                if (x_valid && !reset) begin
                    accept     = 1'b1;
                    state_next = MAC;
                end
            end
            MAC: begin
                if (k == AW'(TAPS - 1)) begin
                    mac_last   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Only non-power-of-two tap counts can see an out-of-range address.
    generate
        if (TAPS == (1 << AW)) begin : g_full_addr
            assign addr_ok = 1'b1;
        end else begin : g_part_addr
            assign addr_ok = (32'(coef_addr) < 32'(TAPS));
        end
    endgenerate

    assign coef_ok = coef_we && (state == IDLE) && addr_ok;

    always_comb begin
        prod     = PW'(d[k]) * PW'(c[k]);
        acc_sum  = acc + ACC_W'(prod);
        // One guard bit so the rounding constant cannot wrap the sum.
        rnd      = (RW'(acc_sum) + RW'(ROUND_ADD)) >>> SHIFT;
        r_w      = CW'(rnd);
        y_next   = r_w[OUT_W-1:0];
        sat_next = 1'b0;
        if (r_w > MAX_C) begin
            y_next   = MAX_C[OUT_W-1:0];
            sat_next = 1'b1;
        end else if (r_w < MIN_C) begin
            y_next   = MIN_C[OUT_W-1:0];
            sat_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                d[i] <= '0;
                c[i] <= COEF_W'(1);
            end
            acc      <= '0;
            k        <= '0;
            y_out    <= '0;
            y_valid  <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            if (coef_ok) begin
                c[coef_addr] <= coef_data;
            end
            if (accept) begin
                d[0] <= x_in;
                for (int i = 1; i < TAPS; i++) begin
                    d[i] <= d[i-1];
                end
                acc <= '0;
                k   <= '0;
            end else if (state == MAC) begin
                acc <= acc_sum;
                k   <= k + 1'b1;
                if (mac_last) begin
                    y_out    <= y_next;
                    sat_flag <= sat_next;
                    y_valid  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/fir_filter_mac.md
# fir_filter_mac

Parametrised, time-multiplexed successor to the team's fixed 8-tap FIR. It provides a generic tap count and widths, run-time programmable coefficients, a valid/ready input handshake, rounding with an output shift, and output saturation with a flag. A single multiply-accumulate unit iterates over the taps, trading throughput for area. It sits in the sample datapath between the ADC/stimulus source and downstream decimation/processing.

## Interface
- DATA_W, 8, input sample width (signed)
- COEF_W, 8, coefficient width (signed)
- TAPS, 8, number of taps (≥2)
- OUT_W, 16, output width (signed)
- SHIFT, 0, arithmetic right shift applied to the accumulator before saturation
- ACC_W, DATA_W+COEF_W+$clog2(TAPS), accumulator width (derived, not overridden)

Ports:
- clk  in  1  clock; single clock domain, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- x_in  in  DATA_W  signed input sample
- x_valid  in  1  sample present
- x_ready  out  1  block can accept a sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(TAPS)  coefficient index k
- coef_data  in  COEF_W  signed coefficient value
- y_out  out  OUT_W  signed filtered output (registered)
- y_valid  out  1  one-cycle pulse: y_out updated
- sat_flag  out  1  registered with y_out; 1 = the result was clamped

## Operation
- State: delay line d[0..TAPS-1] (d[0] newest), coefficient bank c[0..TAPS-1], accumulator acc (ACC_W, signed), tap counter k.
- FSM states:
  - IDLE: x_ready=1.
    - On x_valid&&x_ready: d shifts (d[0]<=x_in, d[i]<=d[i-1]), acc<=0, k<=0, go to MAC.
    - Otherwise hold.
  - MAC: each cycle acc<=acc+d[k]*c[k] (full-precision signed product, sign-extended), k<=k+1.
    - On k==TAPS-1: compute final = acc+d[k]*c[k]. Register y_out/sat_flag from final. Pulse y_valid. Go to IDLE.
- Output arithmetic:
  - If SHIFT>0: r = (final + 2^(SHIFT-1)) >>> SHIFT (round half up). Else r = final.
  - If r > 2^(OUT_W-1)-1: y_out = max, sat_flag=1.
  - If r < -2^(OUT_W-1): y_out = min, sat_flag=1.
  - Otherwise y_out = r, sat_flag=0.
- Coefficient writes:
  - Accepted only in IDLE: c[coef_addr] <= coef_data.
  - coef_we in MAC is ignored; there is no queueing.
  - A write and a sample accept in the same IDLE cycle are both performed. The new coefficient applies to that sample.
  - coef_addr ≥ TAPS (non-power-of-2 TAPS) is ignored.
- y_out and sat_flag hold their last values between y_valid pulses.

## Timing
- Reset (any cycle, including mid-MAC): state<=IDLE, d[*]<=0, c[*]<=1, acc<=0, k<=0, y_out<=0, y_valid<=0, sat_flag<=0.
  - An in-flight computation is discarded; no y_valid is produced for it.
  - x_ready=0 while reset is high; x_ready=1 the first cycle after reset deasserts.
- x_ready = (state==IDLE) && !reset. It is combinational from the state register and does not depend on x_valid.
- Latency: a sample accepted at edge E produces y_valid=1 in the cycle after edge E+TAPS (TAPS MAC cycles).
- Throughput: one sample per TAPS+1 cycles.
  - The y_valid cycle is an IDLE cycle, so x_ready=1 concurrently.
  - A sample may be accepted in the same cycle y_valid is high.
- x_valid while x_ready=0: not consumed. The source must hold x_in/x_valid until it is accepted.
- y_valid is exactly one cycle wide. There is no output backpressure.

## Test plan
- Default params, reset 2 cycles, then samples 1,2,…,8 each held until accepted: y_out sequence = 1,3,6,10,15,21,28,36, sat_flag=0. Each y_valid occurs 8 edges after its accept, and accepts are 9 cycles apart.
- Load c[k]=k+1 (k=0..7) in IDLE, then feed impulse 1 followed by seven 0s: y_out = 1,2,3,4,5,6,7,8.
- Load all c=127, feed 127 repeatedly:
  - y = 16129, 32258, then 32767 with sat_flag=1 from the 3rd output on.
  - After re-reset and reloading c=127, feed -128 repeatedly: y = -16256, -32512, then -32768 with sat_flag=1.
- Hold x_valid=1 continuously and pulse coef_we (addr 0, data 5) during MAC:
  - Accepts occur only when x_ready=1.
  - The write is ignored (c[0] is still 1, verified by an impulse).
  - A write in IDLE takes effect for the sample accepted that same cycle.
- Assert reset 3 cycles after an accept (mid-MAC): no y_valid follows. After release, the delay line is zero and c=1, so input 4 yields y_out=4.
- SHIFT=2, c=1: with samples 1,2 the second result raw=3 gives y_out=1. With fresh reset and samples -1,-2 the raw=-3 result gives y_out=-1. sat_flag=0 in both.
